inst_fetch_unit: RTL

Instruction-fetch stage directly downstream of the PC register. It takes the PC stream and chip-enable, issues in-order read requests to instruction memory, and tolerates variable grant/response latency. Each returned instruction is paired with its PC in a small response FIFO that feeds the IF/ID boundary. The block supports decode-side stall and branch flush, and discards in-flight responses after a flush.

---
 rtl/inst_fetch_unit_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/inst_fetch_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: reset/enable levels,
// default bus widths and the {pc, inst} record handed to decode.
package inst_fetch_unit_pkg;

    localparam logic RstEnable   = 1'b0;
    localparam logic RstDisable  = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    // Default-width view of one delivered instruction.
    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with synchronous clear and async active-low reset.
// dout is the registered head entry; it is valid whenever empty is low.
module fetch_fifo
    import inst_fetch_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign do_push = push & (~full | do_pop);

    // Storage, pointers and occupancy; clear wins over any push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst == RstEnable)
        !(push && full && !pop && !clear));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst == RstEnable)
        !(pop && empty && !clear));

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: issues in-order reads for the PC stream, pairs each
// returned instruction with its PC and buffers it for decode. A branch flush
// kills everything in flight; responses still owed by memory for killed
// requests are counted in `discard` and dropped as they arrive.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = InstAddrBus,
    parameter int DATA_W = InstBus,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              ce,
    output logic              pc_ready,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst,
    output logic              err
);

    // Handshakes: a transfer happens on a rising edge where both sides are
    // high (imem_req&imem_gnt, id_valid&id_ready, ce&pc_ready). A valid side
    // never depends combinationally on its own ready, and id_valid/id_pc/
    // id_inst stay stable until the transfer or a flush.

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } rsp_entry_t;

    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   tag_count;
    logic [CW+1:0]   credit_sum;
    logic            space;
    logic            accept;
    logic            resp_drop;
    logic            resp_take;
    logic            spurious;
    logic            id_pop;
    logic [ADDR_W-1:0] tag_head;
    logic            tag_full;
    logic            tag_empty;
    logic            rsp_full;
    logic            rsp_empty;
    rsp_entry_t      rsp_din;
    rsp_entry_t      rsp_head;

    // Every request reserves a response slot up front, so the response FIFO
    // can never be pushed while full.
    assign credit_sum = (CW+2)'(outstanding) + (CW+2)'(fifo_count) + (CW+2)'(discard);
    assign space      = credit_sum < (CW+2)'(DEPTH);

    assign imem_req  = (rst != RstEnable) & (ce == ChipEnable) & space & ~flush;
    assign imem_addr = pc;
    assign accept    = imem_req & imem_gnt;
    assign pc_ready  = accept;

    // Killed responses arrive before any new ones since memory is in order.
    assign resp_drop = imem_rvalid & (discard != '0);
    assign resp_take = imem_rvalid & (discard == '0) & (outstanding != '0);
    assign spurious  = imem_rvalid & (discard == '0) & (outstanding == '0);

    assign id_valid = ~rsp_empty;
    assign id_pop   = id_valid & id_ready;
    assign id_pc    = rsp_head.pc;
    assign id_inst  = rsp_head.inst;

    assign rsp_din.pc   = tag_head;
    assign rsp_din.inst = imem_rdata;

    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (resp_take),
        .clear (flush),
        .din   (pc),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    fetch_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_rsp_q (
        .clk   (clk),
        .rst   (rst),
        .push  (resp_take),
        .pop   (id_pop),
        .clear (flush),
        .din   (rsp_din),
        .dout  (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (fifo_count)
    );

    // Credit counters and sticky error; a flush moves all live requests
    // (less one answered this very cycle) into the discard count.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            outstanding <= '0;
            discard     <= '0;
            err         <= 1'b0;
        end else begin
            if (spurious) begin
                err <= 1'b1;
            end
            if (flush) begin
                outstanding <= '0;
                discard     <= discard + outstanding - CW'(resp_drop | resp_take);
            end else begin
                outstanding <= outstanding + CW'(accept) - CW'(resp_take);
                discard     <= discard - CW'(resp_drop);
            end
        end
    end

    a_credit_bound: assert property (@(posedge clk) disable iff (rst == RstEnable)
        credit_sum <= (CW+2)'(DEPTH));
    a_tag_tracks: assert property (@(posedge clk) disable iff (rst == RstEnable)
        tag_count == outstanding);
    a_tag_room: assert property (@(posedge clk) disable iff (rst == RstEnable)
        !(accept && tag_full));
    a_tag_present: assert property (@(posedge clk) disable iff (rst == RstEnable)
        !(resp_take && tag_empty));
    a_rsp_room: assert property (@(posedge clk) disable iff (rst == RstEnable)
        !(resp_take && rsp_full && !id_pop));

endmodule
